// File: rtl/multiplier_control.sv
// -----------------------------------------------------------------------------
// multiplier_control
//
// Purpose:
//   Sequencer for an 8-bit signed shift-add multiplier. One Run press clears
//   the A/X accumulator, then runs N_BITS add-then-shift iterations. The last
//   iteration subtracts instead of adding because the multiplier MSB has
//   negative weight in two's complement. This block owns every datapath
//   enable; it never looks at data other than the multiplier bit M.
//
// Ports:
//   Clk           in   system clock, rising edge
//   Reset         in   asynchronous, active-high reset
//   Run           in   start request (level, already synchronous to Clk)
//   ClearA_LoadB  in   load request (level), honoured in IDLE only
//   M             in   current LSB of B (multiplier bit under test)
//   clr_xa        out  clear A and X
//   ld_b          out  load switches into B and clear A and X
//   add_en        out  A <= A + S, X <= sign of sum
//   sub_en        out  A <= A - S, X <= sign of difference
//   shift_en      out  arithmetic right shift of X:A:B
//   busy          out  high in CLEAR, ADD and SHIFT
//   done          out  high in HOLD
//   count         out  current iteration index (debug)
// -----------------------------------------------------------------------------
module multiplier_control #(
    parameter int N_BITS = 8,
    localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Run,
    input  logic          ClearA_LoadB,
    input  logic          M,
    output logic          clr_xa,
    output logic          ld_b,
    output logic          add_en,
    output logic          sub_en,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [CW-1:0] LAST_ITER = CW'(N_BITS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          ld_b_raw;

    // State and iteration counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        clr_xa   = 1'b0;
        ld_b_raw = 1'b0;
        add_en   = 1'b0;
        sub_en   = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A load request is still serviced in the cycle Run is seen.
                ld_b_raw = ClearA_LoadB;
                if (Run) begin
                    state_d = S_CLEAR;
                end
            end

            S_CLEAR: begin
                clr_xa  = 1'b1;
                busy    = 1'b1;
                count_d = '0;
                state_d = S_ADD;
            end

            S_ADD: begin
                // M = 0 still consumes the cycle so latency never depends on data.
                busy = 1'b1;
                if (M) begin
                    if (count_q == LAST_ITER) begin
                        sub_en = 1'b1;
                    end else begin
                        add_en = 1'b1;
                    end
                end
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (count_q == LAST_ITER) begin
                    state_d = S_HOLD;
                end else begin
                    count_d = count_q + CW'(1);
                    state_d = S_ADD;
                end
            end

            S_HOLD: begin
                // Waiting for Run to drop gives one multiply per press.
                done = 1'b1;
                if (!Run) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ld_b is the only output fed straight from an input; mask it so that it
    // reads 0 while Reset is held, like every state-derived output.
    assign ld_b  = ld_b_raw & ~Reset;
    assign count = count_q;

endmodule
